bsg_oddr_link_sequencer: RTL and testbench
==========================================

# bsg_oddr_link_sequencer

Core-clock sequencer that owns the transmit side of an ODDR output channel. After reset it holds the downstream PHY in reset, then drives a calibration pattern, then streams user words under credit-based flow control. Each cycle it presents one registered 2*width_p-bit word (low half first on the wire) plus a valid bit for the PHY, which serializes it at 2x.

## Interface
Parameters:
- width_p, "inv": pins per channel; must be set; the PHY word is 2*width_p bits.
- credits_p, 16: receiver buffer depth in words; credits held at reset release; minimum 1.
- phy_reset_cycles_p, 4: cycles the PHY reset is held after this block leaves reset; minimum 1.
- calib_cycles_p, 64: calibration words sent; minimum 1.

Ports:
- clk_i  in  1  core clock; PHY clk_2x is 2x this, phase-locked.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  user word valid.
- data_i  in  2*width_p  user word.
- ready_o  out  1  word accepted this cycle when v_i & ready_o.
- token_i  in  1  one-cycle credit-return pulse; already synchronized to clk_i.
- phy_reset_o  out  1  active-high reset to the PHY.
- phy_v_o  out  1  phy_data_o carries a user word.
- phy_data_o  out  2*width_p  word to the PHY.
- calib_done_o  out  1  link is in RUN.
- overflow_o  out  1  sticky: token returned with the credit counter full.

## Operation
- States: PHY_RST -> CALIB -> RUN. The only way back to PHY_RST is reset.
- PHY_RST: phy_reset_o=1, phy_v_o=0, phy_data_o=0, ready_o=0. A down-counter loads phy_reset_cycles_p. The block moves to CALIB when the counter hits 0.
- CALIB: phy_reset_o=0, ready_o=0, phy_v_o=0. phy_data_o alternates each cycle between the two patterns below, starting with A:
  - A: upper half all ones, lower half all zeros.
  - B: the inverse of A.
- CALIB lasts exactly calib_cycles_p cycles, then the block moves to RUN.
- RUN: calib_done_o=1.
  - ready_o = (credits != 0). It is combinational from the credit register only and never depends on v_i.
  - Accept (v_i & ready_o): phy_data_o <= data_i, phy_v_o <= 1, credits decrement by 1.
  - No accept: phy_v_o <= 0, phy_data_o <= idle word (all zeros).
  - token_i: credits increment by 1.
- Credit rules:
  - Accept and token in the same cycle: credits unchanged.
  - token_i while credits == credits_p with no accept: credits stay at credits_p and overflow_o sets; it clears only on reset.
  - token_i outside RUN is ignored and does not set overflow_o.
- Credit counter width: $clog2(credits_p+1). It never wraps below 0 because ready_o gates the decrement.
- v_i with ready_o=0: the word is not consumed. The user holds it; no loss and no duplication.

## Timing
- Reset values (asynchronous): state=PHY_RST, phy_reset_o=1, phy_v_o=0, phy_data_o=0, ready_o=0, calib_done_o=0, overflow_o=0, credits=credits_p.
- phy_reset_o deasserts on the clk_i edge that ends cycle phy_reset_cycles_p after reset_n_i rises.
- The first calibration word is on phy_data_o in that same cycle.
- calib_done_o and ready_o rise together, calib_cycles_p cycles after phy_reset_o falls.
- Accept-to-phy_data_o latency: 1 cycle. Sustained throughput: 1 word per cycle while credits last.
- token_i takes effect on credits one edge later, so ready_o can reassert in the cycle after the token.
- All phy_* outputs come directly from flops; no combinational path reaches the PHY.
- Asserting reset_n_i mid-stream clears all state immediately. Any in-flight word is dropped and phy_reset_o rises with no clock.

## Configuration
- BSG_ODDR_LINK_SEQ_CALIB_EN
  - Defined: CALIB state present, as described under Operation.
  - Undefined: CALIB and its counter are not compiled. PHY_RST goes straight to RUN, so calib_done_o and ready_o rise in the cycle phy_reset_o falls. calib_cycles_p is ignored.

## Structure
- bsg_oddr_link_seq_pkg holds:
  - state enum (PHY_RST, CALIB, RUN);
  - calibration pattern polarity constant;
  - idle-word constant.
- Sub-module bsg_oddr_link_seq_credit_cnt holds the saturating up/down credit counter with overflow flag. Its ports are clk_i, reset_n_i, en_i, up_i, down_i, credits_o, overflow_o.

## Test plan
- Reset release, width_p=4, phy_reset_cycles_p=4, calib_cycles_p=8 -> phy_reset_o high for 4 cycles, then phy_data_o = F0,0F,F0,... for 8 cycles, then calib_done_o=1 and ready_o=1.
- credits_p=4, v_i held high, no tokens -> exactly 4 words on phy_data_o with phy_v_o=1, in order, 1-cycle latency. ready_o then drops and phy_v_o returns to 0 with idle zeros.
- Credits at 0, token_i pulses with v_i high -> one word accepted per token, issued the cycle after the token; nothing is dropped or duplicated.
- Accept and token_i in the same cycle for 20 cycles -> credits constant, 20 consecutive words with phy_v_o=1.
- token_i with credits == credits_p -> overflow_o=1 and stays set; credits remain credits_p. token_i during CALIB -> overflow_o stays 0.
- reset_n_i pulsed low mid-stream -> all outputs immediately at reset values; the full sequence restarts. Rerun with the macro undefined -> RUN entered the cycle phy_reset_o falls.

Source files
------------

// File: rtl/bsg_oddr_link_seq_pkg.sv
// Shared types and constants for the ODDR link sequencer: FSM state encoding,
// calibration pattern polarity and the idle word fill bit.
package bsg_oddr_link_seq_pkg;

  typedef enum logic [1:0] {
    StPhyRst = 2'd0,
    StCalib  = 2'd1,
    StRun    = 2'd2
  } state_e;

  // Calibration pattern A drives the upper half with this bit and the lower half with its inverse.
  localparam logic CalibUpperBit = 1'b1;

  // Fill bit for the word presented when no user word is issued.
  localparam logic IdleBit = 1'b0;

endpackage

// File: rtl/bsg_oddr_link_seq_credit_cnt.sv
// Saturating up/down credit counter with a sticky overflow flag. Counts only while en_i is
// high; an up at full scale leaves the count alone and sets the flag until reset.
module bsg_oddr_link_seq_credit_cnt
  import bsg_oddr_link_seq_pkg::*;
#(
  parameter int unsigned credits_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               en_i,
  input  logic                               up_i,
  input  logic                               down_i,
  output logic [$clog2(credits_p + 1)-1:0]   credits_o,
  output logic                               overflow_o
);

  localparam int unsigned CntW = $clog2(credits_p + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(credits_p);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (en_i) begin
      unique case ({up_i, down_i})
        2'b10: begin
          if (cnt_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Callers gate down_i with a non-zero count; the guard keeps the counter safe regardless.
        2'b01: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= CntMax;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign credits_o  = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/bsg_oddr_link_sequencer.sv
// Transmit-side sequencer for an ODDR channel: PHY reset, optional calibration pattern
// (enabled by BSG_ODDR_LINK_SEQ_CALIB_EN), then credit-flow-controlled user words.
module bsg_oddr_link_sequencer
  import bsg_oddr_link_seq_pkg::*;
#(
  parameter int unsigned width_p            = 4,
  parameter int unsigned credits_p          = 16,
  parameter int unsigned phy_reset_cycles_p = 4,
  parameter int unsigned calib_cycles_p     = 64
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [2*width_p-1:0]   data_i,
  output logic                   ready_o,
  input  logic                   token_i,
  output logic                   phy_reset_o,
  output logic                   phy_v_o,
  output logic [2*width_p-1:0]   phy_data_o,
  output logic                   calib_done_o,
  output logic                   overflow_o
);

  localparam int unsigned WordW = 2 * width_p;
  localparam int unsigned CredW = $clog2(credits_p + 1);
  localparam int unsigned RstW  = $clog2(phy_reset_cycles_p + 1);
  localparam logic [WordW-1:0] IdleWord = {WordW{IdleBit}};

  state_e            state_q, state_d;
  logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;
  logic              phy_reset_q, phy_reset_d;
  logic              phy_v_q, phy_v_d;
  logic [WordW-1:0]  phy_data_q, phy_data_d;
  logic [CredW-1:0]  credits;
  logic              in_run;
  logic              accept;

`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
  localparam int unsigned CalibW = (calib_cycles_p > 1) ? $clog2(calib_cycles_p) : 1;
  localparam logic [WordW-1:0] CalibWordA = {{width_p{CalibUpperBit}}, {width_p{~CalibUpperBit}}};
  logic [CalibW-1:0] calib_cnt_q, calib_cnt_d;
`else
  logic unused_calib_cfg;
  assign unused_calib_cfg = ^calib_cycles_p;
`endif

  assign in_run       = (state_q == StRun);
  assign ready_o      = in_run & (credits != '0);
  assign calib_done_o = in_run;
  assign accept       = v_i & ready_o;

  bsg_oddr_link_seq_credit_cnt #(
    .credits_p (credits_p)
  ) u_credit_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (in_run),
    .up_i       (token_i),
    .down_i     (accept),
    .credits_o  (credits),
    .overflow_o (overflow_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StPhyRst;
      rst_cnt_q   <= RstW'(phy_reset_cycles_p);
`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
      calib_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
      calib_cnt_q <= calib_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
    calib_cnt_d = calib_cnt_q;
`endif
    unique case (state_q)
      StPhyRst: begin
        rst_cnt_d = rst_cnt_q - 1'b1;
        if (rst_cnt_q == RstW'(1)) begin
`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
          state_d     = StCalib;
          calib_cnt_d = CalibW'(calib_cycles_p - 1);
`else
          state_d     = StRun;
`endif
        end
      end
`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
      StCalib: begin
        if (calib_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          calib_cnt_d = calib_cnt_q - 1'b1;
        end
      end
`endif
      StRun:   ;
      default: state_d = StPhyRst;
    endcase
  end

  // PHY-facing values are decoded from the next state so the flops present them in that state.
  always_comb begin
    phy_reset_d = 1'b0;
    phy_v_d     = 1'b0;
    phy_data_d  = IdleWord;
    unique case (state_d)
      StPhyRst: phy_reset_d = 1'b1;
`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
      StCalib:  phy_data_d = (state_q == StCalib) ? ~phy_data_q : CalibWordA;
`endif
      StRun: begin
        if (accept) begin
          phy_v_d    = 1'b1;
          phy_data_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phy_reset_q <= 1'b1;
      phy_v_q     <= 1'b0;
      phy_data_q  <= IdleWord;
    end else begin
      phy_reset_q <= phy_reset_d;
      phy_v_q     <= phy_v_d;
      phy_data_q  <= phy_data_d;
    end
  end

  assign phy_reset_o = phy_reset_q;
  assign phy_v_o     = phy_v_q;
  assign phy_data_o  = phy_data_q;

endmodule

// File: tb/tb_bsg_oddr_link_sequencer.sv
// Self-checking bench for bsg_oddr_link_sequencer: bring-up sequence, credit flow control,
// overflow flag and mid-stream reset, with a queue of expected PHY words.
module tb_bsg_oddr_link_sequencer;

  localparam int W       = 4;
  localparam int CREDITS = 4;
  localparam int PHYRST  = 4;
`ifdef BSG_ODDR_LINK_SEQ_CALIB_EN
  localparam int CAL     = 8;
`else
  localparam int CAL     = 0;
`endif
  localparam logic [2*W-1:0] PAT_A = 8'hF0;
  localparam logic [2*W-1:0] PAT_B = 8'h0F;

  logic           clk_i     = 1'b0;
  logic           reset_n_i = 1'b1;
  logic           v_i       = 1'b0;
  logic [2*W-1:0] data_i    = '0;
  logic           token_i   = 1'b0;
  logic           ready_o;
  logic           phy_reset_o;
  logic           phy_v_o;
  logic [2*W-1:0] phy_data_o;
  logic           calib_done_o;
  logic           overflow_o;

  bsg_oddr_link_sequencer #(
    .width_p            (W),
    .credits_p          (CREDITS),
    .phy_reset_cycles_p (PHYRST),
    .calib_cycles_p     (8)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .token_i      (token_i),
    .phy_reset_o  (phy_reset_o),
    .phy_v_o      (phy_v_o),
    .phy_data_o   (phy_data_o),
    .calib_done_o (calib_done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [2*W-1:0] exp_q[$];
  int             model_cred = CREDITS;
  bit             model_run  = 1'b0;
  bit             model_ovf  = 1'b0;
  bit             last_acc   = 1'b0;
  logic [2*W-1:0] next_word  = 8'h10;
  logic [2*W-1:0] exp_w;

  // Drive one cycle of inputs, update the credit model and queue, then settle 1ns past the edge.
  task automatic step(input logic v, input logic [2*W-1:0] d, input logic tok);
    v_i      = v;
    data_i   = d;
    token_i  = tok;
    last_acc = v && model_run && (model_cred != 0);
    if (last_acc) exp_q.push_back(d);
    if (model_run) begin
      if (tok && !last_acc) begin
        if (model_cred == CREDITS) model_ovf = 1'b1;
        else model_cred++;
      end else if (!tok && last_acc) begin
        model_cred--;
      end
    end
    @(posedge clk_i);
    #1;
    token_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    #1 reset_n_i = 1'b0;
    #1;
    got = {phy_reset_o, phy_v_o, phy_data_o, ready_o, calib_done_o, overflow_o};
    n_tests++;
    if (got !== {1'b1, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_async: got %h want %h", got, {1'b1, 12'h000});
    end
    repeat (2) @(posedge clk_i);
    #1;
    got = {phy_reset_o, phy_v_o, phy_data_o, ready_o, calib_done_o, overflow_o};
    n_tests++;
    if (got !== {1'b1, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", got, {1'b1, 12'h000});
    end
  endtask

  // Releases reset and walks PHY_RST (and CALIB when built) into RUN; v_i/token_i are ignored.
  task automatic test_bringup();
    logic [12:0] got, want;
    logic [2*W-1:0] d;
    bit r, run;
    exp_q.delete();
    model_run  = 1'b0;
    model_cred = CREDITS;
    model_ovf  = 1'b0;
    reset_n_i  = 1'b1;
    for (int k = 1; k <= PHYRST + CAL; k++) begin
      step(1'b1, 8'hAA, (k % 3) == 1);
      r   = (k < PHYRST);
      run = (k == PHYRST + CAL);
      d   = 8'h00;
      if (k >= PHYRST && k < PHYRST + CAL) d = ((k - PHYRST) % 2 == 0) ? PAT_A : PAT_B;
      want = {r, 1'b0, d, run, run, 1'b0};
      got  = {phy_reset_o, phy_v_o, phy_data_o, ready_o, calib_done_o, overflow_o};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL bringup_cycle%0d: got %h want %h", k, got, want);
      end
    end
    v_i       = 1'b0;
    model_run = 1'b1;
  endtask

  task automatic test_burst();
    for (int i = 0; i < CREDITS + 3; i++) begin
      n_tests++;
      if (ready_o !== (model_cred != 0)) begin
        n_fail++;
        $display("FAIL burst_ready: got %b want %b", ready_o, model_cred != 0);
      end
      step(1'b1, next_word, 1'b0);
      n_tests++;
      if (last_acc) begin
        next_word++;
        exp_w = exp_q.pop_front();
        if (phy_v_o !== 1'b1 || phy_data_o !== exp_w) begin
          n_fail++;
          $display("FAIL burst_word: got v=%b %h want v=1 %h", phy_v_o, phy_data_o, exp_w);
        end
      end else if (phy_v_o !== 1'b0 || phy_data_o !== 8'h00) begin
        n_fail++;
        $display("FAIL burst_idle: got v=%b %h want v=0 00", phy_v_o, phy_data_o);
      end
    end
    v_i = 1'b0;
  endtask

  // Credits start at 0; each token lets exactly one held word through on the following cycle.
  task automatic test_token_refill();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (ready_o !== (model_cred != 0)) begin
        n_fail++;
        $display("FAIL refill_ready: got %b want %b", ready_o, model_cred != 0);
      end
      step(1'b1, next_word, (i % 2) == 0);
      n_tests++;
      if (last_acc) begin
        next_word++;
        exp_w = exp_q.pop_front();
        if (phy_v_o !== 1'b1 || phy_data_o !== exp_w) begin
          n_fail++;
          $display("FAIL refill_word: got v=%b %h want v=1 %h", phy_v_o, phy_data_o, exp_w);
        end
      end else if (phy_v_o !== 1'b0 || phy_data_o !== 8'h00) begin
        n_fail++;
        $display("FAIL refill_idle: got v=%b %h want v=0 00", phy_v_o, phy_data_o);
      end
    end
    v_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int words;
    words = 0;
    repeat (2) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (ready_o !== (model_cred != 0)) begin
        n_fail++;
        $display("FAIL b2b_ready: got %b want %b", ready_o, model_cred != 0);
      end
      step(1'b1, next_word, 1'b1);
      n_tests++;
      if (last_acc) begin
        next_word++;
        words++;
        exp_w = exp_q.pop_front();
        if (phy_v_o !== 1'b1 || phy_data_o !== exp_w) begin
          n_fail++;
          $display("FAIL b2b_word: got v=%b %h want v=1 %h", phy_v_o, phy_data_o, exp_w);
        end
      end else if (phy_v_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle: got v=%b want v=0", phy_v_o);
      end
    end
    n_tests++;
    if (words != 20) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d words want 20", words);
    end
    v_i = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b1);
  endtask

  // Credits are full here; a token must set the sticky flag without adding a fifth credit.
  task automatic test_overflow();
    n_tests++;
    if (overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_before: got %b want 0", overflow_o);
    end
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (overflow_o !== model_ovf || ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_sticky: got ovf=%b ready=%b want ovf=%b ready=1",
                 overflow_o, ready_o, model_ovf);
      end
      step(1'b0, 8'h00, 1'b0);
    end
    test_burst();
    n_tests++;
    if (overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after_burst: got %b want 1", overflow_o);
    end
  endtask

  task automatic test_reset_midstream();
    logic [12:0] got;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, next_word, 1'b0);
    n_tests++;
    if (last_acc) begin
      next_word++;
      exp_w = exp_q.pop_front();
      if (phy_v_o !== 1'b1 || phy_data_o !== exp_w) begin
        n_fail++;
        $display("FAIL mid_word: got v=%b %h want v=1 %h", phy_v_o, phy_data_o, exp_w);
      end
    end else begin
      n_fail++;
      $display("FAIL mid_accept: got no accept want accept");
    end
    v_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1;
    got = {phy_reset_o, phy_v_o, phy_data_o, ready_o, calib_done_o, overflow_o};
    n_tests++;
    if (got !== {1'b1, 12'h000}) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want %h", got, {1'b1, 12'h000});
    end
    v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_bringup();
    test_burst();
    test_token_refill();
    test_back_to_back();
    test_overflow();
    test_reset_midstream();
    test_bringup();
    test_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
